// File: rtl/spi_slave_receiver.sv
// spi_slave_receiver: SPI mode-0 slave front end; synchronises pins, assembles MSB-first bytes
// and shifts a parallel tx byte out on miso.
module spi_slave_receiver #(
  parameter int SPI_DATA_WIDTH = 8,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      sclk,
  input  logic                      mosi,
  input  logic                      cs,
  output logic                      miso,
  input  logic [SPI_DATA_WIDTH-1:0] to_spi,
  output logic                      tx_taken,
  output logic                      spi_ready,
  output logic [SPI_DATA_WIDTH-1:0] from_spi,
  output logic                      frame_active
);
  localparam int W  = SPI_DATA_WIDTH;
  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] FULL = CW'(W);
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;
  state_t state_q;
  logic [SYNC_STAGES:0]   sclk_q, cs_q;
  logic [SYNC_STAGES-1:0] mosi_q;
  logic                   fall_q, skip_q;
  logic [W-1:0]           rx_q, tx_q, rx_d, tx_d;
  logic [CW-1:0]          cnt_q;
  logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;
  assign sclk_rise = sclk_q[SYNC_STAGES-1] & ~sclk_q[SYNC_STAGES];
  assign sclk_fall = ~sclk_q[SYNC_STAGES-1] & sclk_q[SYNC_STAGES];
  assign cs_rise   = cs_q[SYNC_STAGES-1] & ~cs_q[SYNC_STAGES];
  assign cs_fall   = ~cs_q[SYNC_STAGES-1] & cs_q[SYNC_STAGES];
  assign rx_d      = {rx_q[W-2:0], mosi_q[SYNC_STAGES-1]};
  assign tx_d      = {tx_q[W-2:0], 1'b0};
  // tx_q is zero outside a frame, so its MSB is the registered miso
  assign miso      = tx_q[W-1];
  // cs chain clears to 0: a cs already low at reset release yields no cs_fall
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      sclk_q <= '0;
      cs_q   <= '0;
      mosi_q <= '0;
      fall_q <= 1'b0;
    end else begin
      sclk_q <= {sclk_q[SYNC_STAGES-1:0], sclk};
      cs_q   <= {cs_q[SYNC_STAGES-1:0], cs};
      mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi};
      fall_q <= sclk_fall;
    end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q      <= IDLE;
      rx_q         <= '0;
      tx_q         <= '0;
      cnt_q        <= '0;
      skip_q       <= 1'b0;
      from_spi     <= '0;
      spi_ready    <= 1'b0;
      tx_taken     <= 1'b0;
      frame_active <= 1'b0;
    end else begin
      spi_ready <= 1'b0;
      tx_taken  <= 1'b0;
      if (cs_rise) begin
        state_q      <= IDLE;
        cnt_q        <= '0;
        tx_q         <= '0;
        skip_q       <= 1'b0;
        frame_active <= 1'b0;
      end else if (state_q == IDLE) begin
        if (cs_fall) begin
          state_q      <= LOAD;
          frame_active <= 1'b1;
        end
      end else if (state_q == LOAD) begin
        tx_q     <= to_spi;
        tx_taken <= 1'b1;
        state_q  <= SHIFT;
      end else if (cnt_q == FULL) begin
        from_spi  <= rx_q;
        spi_ready <= 1'b1;
        cnt_q     <= '0;
        tx_q      <= to_spi;
        tx_taken  <= 1'b1;
        skip_q    <= 1'b1;
      end else begin
        if (sclk_rise) begin
          rx_q  <= rx_d;
          cnt_q <= cnt_q + 1'b1;
        end
        // the fall right after a reload must keep the fresh MSB on miso
        if (fall_q) begin
          skip_q <= 1'b0;
          tx_q   <= skip_q ? tx_q : tx_d;
        end
      end
    end
endmodule

// File: tb/tb_spi_slave_receiver.sv
// tb_spi_slave_receiver: directed table plus corner-case sequences for spi_slave_receiver.
module tb_spi_slave_receiver;
  localparam int H = 6;
  logic clk = 1'b0, rst = 1'b0, sclk = 1'b0, mosi = 1'b0, cs = 1'b1;
  logic [7:0] to_spi = 8'h00;
  logic miso, tx_taken, spi_ready, frame_active;
  logic [7:0] from_spi;
  int checks = 0, errors = 0;
  int rdy_cnt = 0, tk_cnt = 0, miso_cnt = 0, wide = 0;
  logic prev_rdy = 1'b0;
  logic [31:0] word = 32'h0;
  always #5 clk = ~clk;
  spi_slave_receiver dut (
    .clk(clk), .rst(rst), .sclk(sclk), .mosi(mosi), .cs(cs), .miso(miso),
    .to_spi(to_spi), .tx_taken(tx_taken), .spi_ready(spi_ready),
    .from_spi(from_spi), .frame_active(frame_active)
  );
  always @(negedge clk) begin
    if (spi_ready) begin
      rdy_cnt++;
      word = {word[23:0], from_spi};
      if (prev_rdy) wide++;
    end
    if (tx_taken) tk_cnt++;
    if (miso) miso_cnt++;
    prev_rdy = spi_ready;
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic spi_bits(input logic [7:0] d, input int n, output logic [7:0] m);
    m = '0;
    for (int i = 0; i < n; i++) begin
      mosi = d[7-i];
      repeat (H) @(negedge clk);
      sclk = 1'b1;
      m[7-i] = miso;
      repeat (H) @(negedge clk);
      sclk = 1'b0;
    end
  endtask
  task automatic open_frame;
    cs = 1'b0;
    repeat (8) @(negedge clk);
  endtask
  task automatic close_frame;
    repeat (H) @(negedge clk);
    cs = 1'b1;
    repeat (12) @(negedge clk);
  endtask
  typedef struct {
    logic [7:0] tx;
    logic [7:0] rx;
    logic [7:0] exp_from;
    logic [7:0] exp_miso;
    int         exp_taken;
  } vec_t;
  vec_t vecs[5];
  initial begin
    logic [7:0] m, m2;
    int r0, t0, w0, c0;
    vecs[0] = '{8'h3C, 8'hA5, 8'hA5, 8'h3C, 2};
    vecs[1] = '{8'hF0, 8'h12, 8'h12, 8'hF0, 2};
    vecs[2] = '{8'h00, 8'hFF, 8'hFF, 8'h00, 2};
    vecs[3] = '{8'hFF, 8'h00, 8'h00, 8'hFF, 2};
    vecs[4] = '{8'h81, 8'h5A, 8'h5A, 8'h81, 2};
    repeat (4) @(negedge clk);
    chk("rst_spi_ready", spi_ready, 0);
    chk("rst_tx_taken", tx_taken, 0);
    chk("rst_frame_active", frame_active, 0);
    chk("rst_miso", miso, 0);
    chk("rst_from_spi", from_spi, 0);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      r0 = rdy_cnt;
      t0 = tk_cnt;
      to_spi = vecs[i].tx;
      open_frame();
      chk($sformatf("v%0d_frame_active", i), frame_active, 1);
      spi_bits(vecs[i].rx, 8, m);
      close_frame();
      chk($sformatf("v%0d_from_spi", i), from_spi, vecs[i].exp_from);
      chk($sformatf("v%0d_miso_bits", i), m, vecs[i].exp_miso);
      chk($sformatf("v%0d_ready_pulses", i), rdy_cnt - r0, 1);
      chk($sformatf("v%0d_tx_taken", i), tk_cnt - t0, vecs[i].exp_taken);
      chk($sformatf("v%0d_frame_closed", i), frame_active, 0);
    end
    r0 = rdy_cnt;
    w0 = wide;
    open_frame();
    spi_bits(8'h12, 8, m);
    spi_bits(8'h34, 8, m);
    spi_bits(8'h56, 8, m);
    spi_bits(8'h78, 8, m);
    close_frame();
    chk("burst_pulses", rdy_cnt - r0, 4);
    chk("burst_wide_pulses", wide - w0, 0);
    chk("burst_word", word, 32'h12345678);
    chk("burst_from_spi", from_spi, 8'h78);
    t0 = tk_cnt;
    to_spi = 8'h3C;
    open_frame();
    to_spi = 8'hF0;
    spi_bits(8'h00, 8, m);
    spi_bits(8'h00, 8, m2);
    close_frame();
    chk("tx_first_byte", m, 8'h3C);
    chk("tx_second_byte", m2, 8'hF0);
    chk("tx_taken_count", tk_cnt - t0, 3);
    r0 = rdy_cnt;
    open_frame();
    spi_bits(8'h55, 8, m);
    spi_bits(8'hFF, 5, m);
    close_frame();
    chk("abort_pulses", rdy_cnt - r0, 1);
    chk("abort_from_spi", from_spi, 8'h55);
    open_frame();
    spi_bits(8'h81, 8, m);
    close_frame();
    chk("after_abort_from_spi", from_spi, 8'h81);
    chk("after_abort_pulses", rdy_cnt - r0, 2);
    to_spi = 8'hFF;
    open_frame();
    spi_bits(8'hC3, 3, m);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst_from_spi", from_spi, 0);
    chk("midrst_miso", miso, 0);
    chk("midrst_frame_active", frame_active, 0);
    chk("midrst_spi_ready", spi_ready, 0);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    chk("postrst_frame_active", frame_active, 0);
    chk("postrst_miso", miso, 0);
    r0 = rdy_cnt;
    spi_bits(8'hFF, 5, m);
    close_frame();
    chk("postrst_pulses", rdy_cnt - r0, 0);
    chk("postrst_from_spi", from_spi, 0);
    open_frame();
    spi_bits(8'hC3, 8, m);
    close_frame();
    chk("fresh_frame_from_spi", from_spi, 8'hC3);
    r0 = rdy_cnt;
    t0 = tk_cnt;
    c0 = miso_cnt;
    for (int i = 0; i < 20; i++) begin
      mosi = 1'($urandom);
      sclk = ~sclk;
      repeat (H) @(negedge clk);
    end
    sclk = 1'b0;
    repeat (10) @(negedge clk);
    chk("idle_pulses", rdy_cnt - r0, 0);
    chk("idle_tx_taken", tk_cnt - t0, 0);
    chk("idle_miso_high", miso_cnt - c0, 0);
    chk("idle_frame_active", frame_active, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_slave_receiver.md
# spi_slave_receiver

Serial front end of the SPI input path. Synchronises the external SPI slave pins (sclk, mosi, cs) into the system clock domain. Assembles MSB-first bytes from mosi and emits each completed byte with a one-cycle `spi_ready` strobe on `from_spi`; the downstream word splitter consumes this strobe and byte. Shifts a byte supplied on `to_spi` out on miso in parallel with reception.

## Interface
- `SPI_DATA_WIDTH`, default 8: bits per SPI byte; shift register, bit counter and data ports are sized from it.
- `SYNC_STAGES`, default 2: flip-flop depth of each input synchroniser. Minimum 2.
- `clk`  input  1  system clock. One clock; reset is asynchronous and active-low.
- `rst`  input  1  asynchronous, active-low reset.
- `sclk`  input  1  SPI clock from master, mode 0 (CPOL=0, CPHA=0). Asynchronous to `clk`.
- `mosi`  input  1  master-out data; sampled on sclk rising edge.
- `cs`  input  1  active-low chip select from master.
- `miso`  output  1  slave-out data; changes on sclk falling edge.
- `to_spi`  input  `SPI_DATA_WIDTH`  next byte to transmit; captured on each tx load.
- `tx_taken`  output  1  one-cycle pulse: `to_spi` was captured into the tx shifter.
- `spi_ready`  output  1  one-cycle pulse: `from_spi` holds a new complete byte.
- `from_spi`  output  `SPI_DATA_WIDTH`  last received byte; held until the next byte completes.
- `frame_active`  output  1  synchronised, inverted `cs`; high while the frame is open.

## Operation
- Input path: each of `sclk`, `mosi` and `cs` passes through a `SYNC_STAGES` flip-flop chain. One extra stage on `sclk` and on `cs` gives edge detection: `sclk_rise`, `sclk_fall`, `cs_fall`, `cs_rise`, each one `clk` cycle wide.
- FSM states:
  - IDLE: `cs` high. Bit counter is 0. `miso` = 0.
  - LOAD: one cycle, entered on `cs_fall`. Tx shifter <= `to_spi`, `tx_taken` pulses, then go to SHIFT.
  - SHIFT:
    - On `sclk_rise`: rx shifter <= {rx[W-2:0], mosi_sync}; counter increments.
    - On `sclk_fall`: tx shifter shifts left by one, filling with 0.
  - Transitions:
    - `cs_rise` in any state goes to IDLE.
    - `cs_fall` and `cs_rise` seen on the same cycle (glitch): stay IDLE.
- Byte completion: on the `sclk_rise` that makes counter = `SPI_DATA_WIDTH`:
  - Next cycle: `from_spi` <= assembled byte, `spi_ready` = 1 for exactly one cycle, counter <= 0.
  - Same cycle: tx shifter reloads from `to_spi` and `tx_taken` pulses. This `sclk_fall` does not shift, so the MSB of the new byte is on `miso` for the next bit period.
- `miso` = MSB of the tx shifter while in SHIFT or LOAD; 0 in IDLE.
- Aborted byte: `cs_rise` with counter in 1..`SPI_DATA_WIDTH`-1:
  - partial byte discarded;
  - no `spi_ready`;
  - `from_spi` keeps its previous value;
  - counter <= 0.
- `sclk` edges while in IDLE are ignored.
- Reset values (on `rst`=0, asynchronous):
  - `spi_ready`, `tx_taken`, `frame_active`, `miso` all 0;
  - `from_spi` = 0;
  - all shifters, the counter and the synchronisers cleared;
  - state = IDLE.
- Reset mid-frame: after release, the block waits in IDLE for a fresh `cs_fall`. `cs` already low at release does not start a frame.

## Timing
- Constraint: sclk high and low times ≥ (`SYNC_STAGES`+2) `clk` periods each. With defaults, sclk ≤ clk/8.
- Constraint: `cs` low to first sclk rise ≥ `SYNC_STAGES`+3 `clk` cycles, so that LOAD completes and `miso` is valid.
- Rx latency: `spi_ready` asserts `SYNC_STAGES`+2 `clk` cycles after the last sclk rising edge of a byte at the pin.
- Strobe spacing: consecutive `spi_ready` pulses are always separated by at least one low cycle, guaranteed by the sclk constraint. Downstream relies on this.
- Tx latency: `miso` follows an sclk fall at the pin by `SYNC_STAGES`+2 `clk` cycles.
- `to_spi` must be stable from the `tx_taken` of the previous byte until the next load.
- `frame_active` follows `cs` with `SYNC_STAGES`+1 cycles of delay.

## Test plan
- Single byte: `cs` low, master sends 0xA5 MSB-first, `cs` high -> exactly one `spi_ready` pulse; `from_spi`=0xA5, held afterwards.
- Burst of four bytes 0x12, 0x34, 0x56, 0x78 in one frame -> four single-cycle `spi_ready` pulses, each followed by ≥1 low cycle; with the downstream splitter attached (DATA_WIDTH=32), its output word = 0x12345678.
- Transmit: `to_spi`=0x3C before `cs` fall -> `miso` at the eight sclk rising edges reads 0,0,1,1,1,1,0,0. Then change `to_spi` to 0xF0 -> the next byte reads 1,1,1,1,0,0,0,0; `tx_taken` pulses once per load.
- Abort: 0x55 completed, then 5 bits sent, then `cs` high -> no second `spi_ready`; `from_spi` stays 0x55; the next frame's byte 0x81 is received correctly.
- Reset mid-byte: assert `rst` low after 3 bits, release with `cs` still low -> all outputs 0; the remaining bits produce no `spi_ready`; the next `cs` cycle sends 0xC3 -> `from_spi`=0xC3.
- Idle noise: toggle `sclk` and `mosi` with `cs` high -> no `spi_ready`, no `tx_taken`, `miso` stays 0.
